output_arbiter: RTL and testbench
=================================

OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 SHALL have parameter MSB_SLOT, default 5, log2 of flit width.
REQ-002 SHALL have parameter DSIZE, default 1<<MSB_SLOT (32), flit width in bits.
REQ-003 SHALL have parameter NPORTS, default 5, number of competing input ports (L=0, N=1, E=2, S=3, W=4).
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-006 SHALL have port in_valid, input, NPORTS, per-port flit-present flag, bit i = port i.
REQ-007 SHALL have port in_data, input, NPORTS*DSIZE, per-port flits; port i at bits [i*DSIZE +: DSIZE].
REQ-008 SHALL have port in_tail, input, NPORTS, per-port last-flit-of-packet flag.
REQ-009 SHALL have port in_ready, output, NPORTS, per-port accept; a flit transfers when in_valid[i] and in_ready[i] are both 1 at a rising edge.
REQ-010 SHALL have port out_valid, output, 1, output register holds a flit.
REQ-011 SHALL have port out_data, output, DSIZE, forwarded flit.
REQ-012 SHALL have port out_tail, output, 1, tail flag of forwarded flit.
REQ-013 SHALL have port out_src, output, 3, port index the current out_data came from.
REQ-014 SHALL have port out_ready, input, 1, downstream accept; output transfers when out_valid and out_ready are both 1.
REQ-015 SHALL have port flit_count, output, 16, count of flits accepted on the output since reset.

Function
REQ-016 SHALL implement states IDLE (no packet owner) and LOCKED (owner holds output until its tail).
REQ-017 SHALL define slot_free = !out_valid || out_ready.
REQ-018 In IDLE with slot_free, SHALL grant the first valid port searching from rr_ptr upward, wrapping NPORTS-1 to 0, and raise in_ready for that port only, combinationally.
REQ-019 In LOCKED, SHALL raise in_ready only for the owner and only when slot_free; no other port is ever granted mid-packet.
REQ-020 At most one in_ready bit SHALL be 1 in any cycle.
REQ-021 On an accepted flit, SHALL load out_data, out_tail, out_src, and set out_valid at that edge: 1-cycle latency, 1 flit/cycle sustained throughput.
REQ-022 If slot_free is 0, out_valid/out_data/out_tail/out_src SHALL hold stable.
REQ-023 If out_ready=1 and no flit is accepted, out_valid SHALL clear at the edge.
REQ-024 An accepted non-tail flit in IDLE SHALL move to LOCKED with owner = granted port.
REQ-025 An accepted tail flit in any state SHALL return to IDLE and set rr_ptr = (source+1) mod NPORTS.
REQ-026 A single-flit packet (head with in_tail=1) SHALL leave the state in IDLE and still advance rr_ptr.
REQ-027 Owner deasserting in_valid mid-packet SHALL keep LOCKED and insert bubbles (out_valid=0 once drained).
REQ-028 No valid ports in IDLE SHALL leave rr_ptr and state unchanged.
REQ-029 flit_count SHALL increment by 1 on each output transfer and wrap 0xFFFF to 0x0000.

Reset
REQ-030 While reset=0, SHALL force state=IDLE, rr_ptr=0, out_valid=0, out_data=0, out_tail=0, out_src=0, flit_count=0, in_ready=0, regardless of clk.
REQ-031 Reset mid-packet SHALL discard the partial packet and the output register, with no residual lock after release.
REQ-032 The first arbitration after reset release SHALL search from port 0.

Structure
REQ-033 Port encodings (L/N/E/S/W), MSB_SLOT/DSIZE defaults, and the state encoding SHALL live in the shared NoC package used by input_router.
REQ-034 SHALL instantiate one sub-module rr_arbiter (NPORTS-wide request vector, pointer in, one-hot grant out, purely combinational); the lock FSM and output register stay in output_arbiter.

Verification
REQ-035 Reset, then in_valid=5'b00100, data 0x0100BBBB tail=1, out_ready=1 -> in_ready=5'b00100, out_valid next cycle, out_data=0x0100BBBB, out_src=2, flit_count=1.
REQ-036 Ports 1 and 3 both valid with single-flit packets, rr_ptr=0 -> port 1 granted first, then port 3, then port 1: round-robin fairness.
REQ-037 Port 4 sends 3-flit packet 0x00000001/2/3 (tail on 3rd) while port 0 valid -> port 0 in_ready=0 until port 4 tail accepted; output order 1,2,3, then port 0's flit.
REQ-038 out_ready held 0 for 4 cycles with out_valid=1 -> out_data stable, all in_ready=0; on release the flow resumes with no loss or duplication.
REQ-039 reset=0 asserted between flits 2 and 3 of a LOCKED packet -> out_valid=0 immediately; after release port 0's waiting flit is granted first.
REQ-040 65536 single-flit transfers -> flit_count wraps to 0x0000.

Source files
------------

// File: rtl/output_arbiter_pkg.sv
// Shared NoC definitions: port encodings, flit-width defaults and the output lock-state encoding.
package output_arbiter_pkg;

   localparam int MSB_SLOT_DEF = 5;
   localparam int DSIZE_DEF    = 1 << MSB_SLOT_DEF;
   localparam int NPORTS_DEF   = 5;
   localparam int SRC_W        = 3;

   typedef enum logic [SRC_W-1:0] {
      PORT_L = 3'd0,
      PORT_N = 3'd1,
      PORT_E = 3'd2,
      PORT_S = 3'd3,
      PORT_W = 3'd4
   } port_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

   function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] p, input int n);
      if (int'(p) >= n - 1) return '0;
      return p + 1'b1;
   endfunction

endpackage

// File: rtl/output_arbiter_rr.sv
// Round-robin pick: first set request at or above ptr, wrapping; one-hot grant, purely combinational.
module rr_arbiter
   import output_arbiter_pkg::*;
#(
   parameter int NPORTS = NPORTS_DEF
) (
   input  logic [NPORTS-1:0] req,
   input  logic [SRC_W-1:0]  ptr,
   output logic [NPORTS-1:0] grant
);

   int   idx;
   logic found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int off = 0; off < NPORTS; off++) begin
         idx = (int'(ptr) + off) % NPORTS;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/output_arbiter.sv
// Packet-locked round-robin output arbiter; 1-cycle latency, 1 flit/cycle.
// Backpressure: in_ready drops for everyone while the output register is full and out_ready is low.
module output_arbiter
   import output_arbiter_pkg::*;
#(
   parameter int MSB_SLOT = MSB_SLOT_DEF,
   parameter int DSIZE    = 1 << MSB_SLOT,
   parameter int NPORTS   = NPORTS_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NPORTS-1:0]       in_valid,
   input  logic [NPORTS*DSIZE-1:0] in_data,
   input  logic [NPORTS-1:0]       in_tail,
   output logic [NPORTS-1:0]       in_ready,
   output logic                    out_valid,
   output logic [DSIZE-1:0]        out_data,
   output logic                    out_tail,
   output logic [SRC_W-1:0]        out_src,
   input  logic                    out_ready,
   output logic [15:0]             flit_count
);

   arb_state_e        state, state_nxt;
   logic [SRC_W-1:0]  rr_ptr, rr_nxt, owner, owner_nxt, src;
   logic [NPORTS-1:0] req, grant;
   logic              slot_free, accept, sel_tail;
   logic [DSIZE-1:0]  sel_data;

   assign slot_free = !out_valid || out_ready;
   assign req       = (state == ST_IDLE) ? in_valid : '0;

   rr_arbiter #(.NPORTS(NPORTS)) u_rr (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (grant)
   );

   always_comb begin
      src = owner;
      if (state == ST_IDLE) begin
         src = '0;
         for (int i = 0; i < NPORTS; i++)
            if (grant[i]) src = SRC_W'(i);
      end
      // in_ready is gated by reset so it reads 0 while reset is held, even with ports valid
      in_ready = '0;
      if (reset && slot_free)
         in_ready = (state == ST_IDLE) ? grant : (NPORTS'(1) << owner);
      accept   = |(in_ready & in_valid);
      sel_data = in_data[int'(src)*DSIZE +: DSIZE];
      sel_tail = in_tail[src];
   end

   always_comb begin
      state_nxt = state;
      rr_nxt    = rr_ptr;
      owner_nxt = owner;
      if (accept) begin
         if (sel_tail) begin
            state_nxt = ST_IDLE;
            rr_nxt    = next_ptr(src, NPORTS);
         end else if (state == ST_IDLE) begin
            state_nxt = ST_LOCKED;
            owner_nxt = src;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         rr_ptr <= 3'(PORT_L);
         owner  <= '0;
      end else begin
         state  <= state_nxt;
         rr_ptr <= rr_nxt;
         owner  <= owner_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_tail   <= 1'b0;
         out_src    <= '0;
         flit_count <= '0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_tail  <= sel_tail;
            out_src   <= src;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (out_valid && out_ready) flit_count <= flit_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter: reset, round-robin, packet lock, backpressure, mid-packet reset, counter wrap.
module tb_output_arbiter;

   localparam int NP = 5;
   localparam int DW = 32;

   logic           clk = 1'b0;
   logic           reset;
   logic [NP-1:0]  in_valid;
   logic [NP*DW-1:0] in_data;
   logic [NP-1:0]  in_tail;
   logic [NP-1:0]  in_ready;
   logic           out_valid;
   logic [DW-1:0]  out_data;
   logic           out_tail;
   logic [2:0]     out_src;
   logic           out_ready;
   logic [15:0]    flit_count;

   int checks   = 0;
   int failures = 0;

   output_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_tail    (in_tail),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_tail   (out_tail),
      .out_src    (out_src),
      .out_ready  (out_ready),
      .flit_count (flit_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic [31:0] d, input logic t);
      in_data[p*DW +: DW] = d;
      in_tail[p]          = t;
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      in_valid  = '0;
      out_ready = 1'b1;
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      in_data   = '0;
      in_tail   = '0;
      in_valid  = 5'b11111;
      out_ready = 1'b1;
      reset     = 1'b0;
      #2;
      check("rst_in_ready", 32'(in_ready), 32'h0);
      tick();
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_out_src", 32'(out_src), 32'h0);
      check("rst_flit_count", 32'(flit_count), 32'h0);
      do_reset();

      // single flit from port E
      set_port(2, 32'h0100BBBB, 1'b1);
      in_valid = 5'b00100;
      #1;
      check("sf_in_ready", 32'(in_ready), 32'h04);
      tick();
      in_valid = '0;
      check("sf_out_valid", 32'(out_valid), 32'h1);
      check("sf_out_data", out_data, 32'h0100BBBB);
      check("sf_out_src", 32'(out_src), 32'h2);
      check("sf_out_tail", 32'(out_tail), 32'h1);
      tick();
      check("sf_flit_count", 32'(flit_count), 32'h1);
      check("sf_drained", 32'(out_valid), 32'h0);

      // round-robin between ports 1 and 3
      do_reset();
      set_port(1, 32'h11, 1'b1);
      set_port(3, 32'h33, 1'b1);
      in_valid = 5'b01010;
      #1;
      check("rr_grant0", 32'(in_ready), 32'h02);
      tick();
      check("rr_src0", 32'(out_src), 32'h1);
      check("rr_grant1", 32'(in_ready), 32'h08);
      tick();
      check("rr_src1", 32'(out_src), 32'h3);
      check("rr_data1", out_data, 32'h33);
      check("rr_grant2", 32'(in_ready), 32'h02);
      tick();
      check("rr_src2", 32'(out_src), 32'h1);
      check("rr_data2", out_data, 32'h11);
      in_valid = '0;
      tick();

      // 3-flit packet from port W holds off port L
      do_reset();
      set_port(4, 32'h1, 1'b0);
      in_valid = 5'b10000;
      #1;
      check("lk_grant_w", 32'(in_ready), 32'h10);
      tick();
      set_port(0, 32'hA0, 1'b1);
      set_port(4, 32'h2, 1'b0);
      in_valid = 5'b10001;
      #1;
      check("lk_hold1", 32'(in_ready), 32'h10);
      check("lk_out1", out_data, 32'h1);
      tick();
      set_port(4, 32'h3, 1'b1);
      #1;
      check("lk_hold2", 32'(in_ready), 32'h10);
      check("lk_out2", out_data, 32'h2);
      tick();
      in_valid = 5'b00001;
      #1;
      check("lk_out3", out_data, 32'h3);
      check("lk_out3_tail", 32'(out_tail), 32'h1);
      check("lk_out3_src", 32'(out_src), 32'h4);
      check("lk_grant_l", 32'(in_ready), 32'h01);
      tick();
      in_valid = '0;
      check("lk_out_l", out_data, 32'hA0);
      check("lk_out_l_src", 32'(out_src), 32'h0);
      tick();

      // output stall for 4 cycles mid-packet
      do_reset();
      set_port(1, 32'h51, 1'b0);
      in_valid = 5'b00010;
      tick();
      out_ready = 1'b0;
      set_port(1, 32'h52, 1'b1);
      set_port(3, 32'h53, 1'b1);
      in_valid = 5'b01010;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("st_in_ready", 32'(in_ready), 32'h0);
         check("st_out_data", out_data, 32'h51);
         check("st_out_valid", 32'(out_valid), 32'h1);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("st_resume_grant", 32'(in_ready), 32'h02);
      tick();
      check("st_out_52", out_data, 32'h52);
      check("st_cnt1", 32'(flit_count), 32'h1);
      in_valid = 5'b01000;
      #1;
      check("st_grant3", 32'(in_ready), 32'h08);
      tick();
      in_valid = '0;
      check("st_out_53", out_data, 32'h53);
      check("st_cnt2", 32'(flit_count), 32'h2);
      tick();
      check("st_cnt3", 32'(flit_count), 32'h3);

      // reset between flits 2 and 3 of a locked packet
      do_reset();
      set_port(2, 32'hE1, 1'b0);
      in_valid = 5'b00100;
      tick();
      set_port(2, 32'hE2, 1'b0);
      set_port(0, 32'hA5, 1'b1);
      in_valid = 5'b00101;
      tick();
      check("mr_pre_data", out_data, 32'hE2);
      set_port(2, 32'hE3, 1'b1);
      reset = 1'b0;
      #1;
      check("mr_out_valid", 32'(out_valid), 32'h0);
      check("mr_in_ready", 32'(in_ready), 32'h0);
      tick();
      reset = 1'b1;
      #1;
      check("mr_grant_l", 32'(in_ready), 32'h01);
      tick();
      in_valid = '0;
      check("mr_out_src", 32'(out_src), 32'h0);
      check("mr_out_data", out_data, 32'hA5);
      tick();

      // counter wrap after 65536 transfers
      do_reset();
      set_port(0, 32'hC0, 1'b1);
      in_valid = 5'b00001;
      repeat (65536) tick();
      check("wr_ffff", 32'(flit_count), 32'hFFFF);
      tick();
      check("wr_zero", 32'(flit_count), 32'h0);
      in_valid = '0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
